ls_queue: RTL and testbench

LS_QUEUE -- requirements
Module: ls_queue

---
 rtl/ls_queue_pkg.sv | 45 ++++
 rtl/ls_queue_if.sv | 63 ++++++
 rtl/ls_load_ext.sv | 22 ++
 rtl/ls_queue.sv | 190 +++++++++++++++++++
 tb/tb_ls_queue.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ls_queue_pkg.sv
// Shared configuration for the load/store queue: opcodes, data width, FSM states
// and small decode helpers used by the queue and its load extender.
package ls_queue_pkg;

  localparam int XLEN      = 32;
  localparam int OP_W      = 6;
  localparam int ROB_W_DEF = 4;

  localparam logic [OP_W-1:0] op_lb  = 6'd0;
  localparam logic [OP_W-1:0] op_lh  = 6'd1;
  localparam logic [OP_W-1:0] op_lw  = 6'd2;
  localparam logic [OP_W-1:0] op_lbu = 6'd3;
  localparam logic [OP_W-1:0] op_lhu = 6'd4;
  localparam logic [OP_W-1:0] op_sb  = 6'd5;
  localparam logic [OP_W-1:0] op_sh  = 6'd6;
  localparam logic [OP_W-1:0] op_sw  = 6'd7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_DRAIN    = 2'd2
  } ls_state_t;

  function automatic logic is_store(input logic [OP_W-1:0] op);
    return (op == op_sb) || (op == op_sh) || (op == op_sw);
  endfunction

  function automatic logic [2:0] op_bytes(input logic [OP_W-1:0] op);
    case (op)
      op_lb, op_lbu, op_sb: return 3'd1;
      op_lh, op_lhu, op_sh: return 3'd2;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_data(input logic [OP_W-1:0] op,
                                                 input logic [XLEN-1:0] v);
    case (op_bytes(op))
      3'd1:    return {24'd0, v[7:0]};
      3'd2:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

endpackage

// File: rtl/ls_queue_if.sv
// Bundle of all non-clock/reset signals of the load/store queue.
interface ls_queue_if
  import ls_queue_pkg::*;
#(parameter int ROB_W = ROB_W_DEF);

  // Handshakes: an issue is taken on a rising edge with rdy high when
  // issue_valid is high and the queue is not full (lsq_avail reflects this
  // combinationally). mem_req_valid is a one-cycle pulse with no back-pressure;
  // mem_resp_valid is a one-cycle completion for the single outstanding request.
  // out_valid is a one-cycle completion pulse to the ROB.
  logic              rdy;
  logic              flush;
  logic              issue_valid;
  logic [OP_W-1:0]   issue_op;
  logic [XLEN-1:0]   issue_imm;
  logic [ROB_W-1:0]  issue_rd_rob;
  logic [XLEN-1:0]   issue_rs1_val;
  logic [XLEN-1:0]   issue_rs2_val;
  logic [ROB_W-1:0]  issue_rs1_rob;
  logic [ROB_W-1:0]  issue_rs2_rob;
  logic              issue_rs1_rdy;
  logic              issue_rs2_rdy;
  logic              lsq_avail;
  logic              mem_req_valid;
  logic              mem_req_we;
  logic [XLEN-1:0]   mem_req_addr;
  logic [2:0]        mem_req_bytes;
  logic [XLEN-1:0]   mem_req_wdata;
  logic              mem_resp_valid;
  logic [XLEN-1:0]   mem_resp_data;
  logic              store_commit_ok;
  logic              cdb0_valid;
  logic [ROB_W-1:0]  cdb0_rob;
  logic [XLEN-1:0]   cdb0_data;
  logic              cdb1_valid;
  logic [ROB_W-1:0]  cdb1_rob;
  logic [XLEN-1:0]   cdb1_data;
  logic              out_valid;
  logic [ROB_W-1:0]  out_rob;
  logic [XLEN-1:0]   out_data;
  ls_state_t         dbg_state;

  modport slave (
    input  rdy, flush, issue_valid, issue_op, issue_imm, issue_rd_rob,
           issue_rs1_val, issue_rs2_val, issue_rs1_rob, issue_rs2_rob,
           issue_rs1_rdy, issue_rs2_rdy, mem_resp_valid, mem_resp_data,
           store_commit_ok, cdb0_valid, cdb0_rob, cdb0_data,
           cdb1_valid, cdb1_rob, cdb1_data,
    output lsq_avail, mem_req_valid, mem_req_we, mem_req_addr, mem_req_bytes,
           mem_req_wdata, out_valid, out_rob, out_data, dbg_state
  );

  modport master (
    output rdy, flush, issue_valid, issue_op, issue_imm, issue_rd_rob,
           issue_rs1_val, issue_rs2_val, issue_rs1_rob, issue_rs2_rob,
           issue_rs1_rdy, issue_rs2_rdy, mem_resp_valid, mem_resp_data,
           store_commit_ok, cdb0_valid, cdb0_rob, cdb0_data,
           cdb1_valid, cdb1_rob, cdb1_data,
    input  lsq_avail, mem_req_valid, mem_req_we, mem_req_addr, mem_req_bytes,
           mem_req_wdata, out_valid, out_rob, out_data, dbg_state
  );

endinterface

// File: rtl/ls_load_ext.sv
// Shapes raw memory read data into the ROB result according to the load opcode.
module ls_load_ext
  import ls_queue_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] data,
  output logic [XLEN-1:0] ext
);

  always_comb begin
    ext = '0;
    case (op)
      op_lb:   ext = {{24{data[7]}}, data[7:0]};
      op_lh:   ext = {{16{data[15]}}, data[15:0]};
      op_lw:   ext = data;
      op_lbu:  ext = {24'd0, data[7:0]};
      op_lhu:  ext = {16'd0, data[15:0]};
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: operand wakeup from two CDBs, one outstanding
// memory access at the head, completion to the ROB.
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ROB_W = ROB_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  ls_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     head, tail;
  logic [CW-1:0]     count;
  logic              valid_q   [DEPTH];
  logic [OP_W-1:0]   op_q      [DEPTH];
  logic [XLEN-1:0]   imm_q     [DEPTH];
  logic [ROB_W-1:0]  rd_q      [DEPTH];
  logic [XLEN-1:0]   rs1_val_q [DEPTH];
  logic [XLEN-1:0]   rs2_val_q [DEPTH];
  logic [ROB_W-1:0]  rs1_rob_q [DEPTH];
  logic [ROB_W-1:0]  rs2_rob_q [DEPTH];
  logic              rs1_rdy_q [DEPTH];
  logic              rs2_rdy_q [DEPTH];

  ls_state_t         state, state_next;
  logic              do_req, do_pop, head_ready, issue_acc;
  logic [XLEN-1:0]   in_rs1_val, in_rs2_val, ext_data;
  logic              in_rs1_rdy, in_rs2_rdy;

  assign bus.lsq_avail = ({1'b0, count} + {{CW{1'b0}}, bus.issue_valid}) < (CW+1)'(DEPTH);
  assign issue_acc     = bus.issue_valid && (count != CW'(DEPTH));
  assign head_ready    = (count != '0) && valid_q[head] && rs1_rdy_q[head] && rs2_rdy_q[head];
  assign bus.dbg_state = state;

  ls_load_ext u_ext (
    .op   (op_q[head]),
    .data (bus.mem_resp_data),
    .ext  (ext_data)
  );

  // An operand arriving on a CDB in the issue cycle is captured directly; port 1 wins.
  always_comb begin
    in_rs1_val = bus.issue_rs1_val;
    in_rs1_rdy = bus.issue_rs1_rdy;
    in_rs2_val = bus.issue_rs2_val;
    in_rs2_rdy = bus.issue_rs2_rdy;
    if (!bus.issue_rs1_rdy) begin
      if (bus.cdb0_valid && bus.cdb0_rob == bus.issue_rs1_rob) begin
        in_rs1_val = bus.cdb0_data; in_rs1_rdy = 1'b1;
      end
      if (bus.cdb1_valid && bus.cdb1_rob == bus.issue_rs1_rob) begin
        in_rs1_val = bus.cdb1_data; in_rs1_rdy = 1'b1;
      end
    end
    if (!bus.issue_rs2_rdy) begin
      if (bus.cdb0_valid && bus.cdb0_rob == bus.issue_rs2_rob) begin
        in_rs2_val = bus.cdb0_data; in_rs2_rdy = 1'b1;
      end
      if (bus.cdb1_valid && bus.cdb1_rob == bus.issue_rs2_rob) begin
        in_rs2_val = bus.cdb1_data; in_rs2_rdy = 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state;
    do_req     = 1'b0;
    do_pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (head_ready && (!is_store(op_q[head]) || bus.store_commit_ok)) begin
          do_req     = 1'b1;
          state_next = ST_WAIT_MEM;
        end
      end
      ST_WAIT_MEM: begin
        if (bus.mem_resp_valid) begin
          do_pop     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (bus.mem_resp_valid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (bus.rdy) begin
      if (bus.flush) state <= (state == ST_WAIT_MEM) ? ST_DRAIN : ST_IDLE;
      else           state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i]   <= 1'b0;
        rs1_rdy_q[i] <= 1'b0;
        rs2_rdy_q[i] <= 1'b0;
      end
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we    <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_req_bytes <= '0;
      bus.mem_req_wdata <= '0;
      bus.out_valid     <= 1'b0;
      bus.out_rob       <= '0;
      bus.out_data      <= '0;
    end else if (bus.rdy) begin
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_we    <= 1'b0;
      bus.out_valid     <= 1'b0;
      if (bus.flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          valid_q[i]   <= 1'b0;
          rs1_rdy_q[i] <= 1'b0;
          rs2_rdy_q[i] <= 1'b0;
        end
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (valid_q[i] && !rs1_rdy_q[i]) begin
            if (bus.cdb0_valid && bus.cdb0_rob == rs1_rob_q[i]) begin
              rs1_val_q[i] <= bus.cdb0_data; rs1_rdy_q[i] <= 1'b1;
            end
            if (bus.cdb1_valid && bus.cdb1_rob == rs1_rob_q[i]) begin
              rs1_val_q[i] <= bus.cdb1_data; rs1_rdy_q[i] <= 1'b1;
            end
          end
          if (valid_q[i] && !rs2_rdy_q[i]) begin
            if (bus.cdb0_valid && bus.cdb0_rob == rs2_rob_q[i]) begin
              rs2_val_q[i] <= bus.cdb0_data; rs2_rdy_q[i] <= 1'b1;
            end
            if (bus.cdb1_valid && bus.cdb1_rob == rs2_rob_q[i]) begin
              rs2_val_q[i] <= bus.cdb1_data; rs2_rdy_q[i] <= 1'b1;
            end
          end
        end
        if (do_req) begin
          bus.mem_req_valid <= 1'b1;
          bus.mem_req_we    <= is_store(op_q[head]);
          bus.mem_req_addr  <= rs1_val_q[head] + imm_q[head];
          bus.mem_req_bytes <= op_bytes(op_q[head]);
          bus.mem_req_wdata <= store_data(op_q[head], rs2_val_q[head]);
        end
        if (do_pop) begin
          valid_q[head] <= 1'b0;
          head          <= head + 1'b1;
          bus.out_valid <= 1'b1;
          bus.out_rob   <= rd_q[head];
          bus.out_data  <= ext_data;
        end
        // The tail slot is free whenever an issue is accepted, so this never collides with wakeup or pop.
        if (issue_acc) begin
          valid_q[tail]   <= 1'b1;
          op_q[tail]      <= bus.issue_op;
          imm_q[tail]     <= bus.issue_imm;
          rd_q[tail]      <= bus.issue_rd_rob;
          rs1_val_q[tail] <= in_rs1_val;
          rs2_val_q[tail] <= in_rs2_val;
          rs1_rob_q[tail] <= bus.issue_rs1_rob;
          rs2_rob_q[tail] <= bus.issue_rs2_rob;
          rs1_rdy_q[tail] <= in_rs1_rdy;
          rs2_rdy_q[tail] <= in_rs2_rdy;
          tail            <= tail + 1'b1;
        end
        case ({issue_acc, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ls_queue.sv
// Directed self-checking bench for ls_queue with a scoreboard for the fill/wrap run.
module tb_ls_queue;
  import ls_queue_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic sb_on   = 1'b0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_data_q[$];
  logic [31:0] exp_rob_q[$];

  ls_queue_if #(.ROB_W(4)) bus ();

  ls_queue #(.DEPTH(16), .ROB_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- check / driver tasks ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_issue(input logic [5:0] op, input logic [31:0] imm, input logic [3:0] rd,
                             input logic [31:0] rs1v, input logic rs1r, input logic [3:0] rs1t,
                             input logic [31:0] rs2v);
    bus.issue_valid   = 1'b1;
    bus.issue_op      = op;
    bus.issue_imm     = imm;
    bus.issue_rd_rob  = rd;
    bus.issue_rs1_val = rs1v;
    bus.issue_rs1_rdy = rs1r;
    bus.issue_rs1_rob = rs1t;
    bus.issue_rs2_val = rs2v;
    bus.issue_rs2_rdy = 1'b1;
    bus.issue_rs2_rob = 4'd0;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] imm, input logic [3:0] rd,
                       input logic [31:0] rs1v, input logic [31:0] rs2v);
    drive_issue(op, imm, rd, rs1v, 1'b1, 4'd0, rs2v);
    tick();
    bus.issue_valid = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!bus.mem_req_valid && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.mem_req_valid), 32'd1);
  endtask

  task automatic wait_busy(input string tag);
    int n = 0;
    while (bus.dbg_state != ST_WAIT_MEM && n < 50) begin
      tick();
      n++;
    end
    check(tag, 32'(bus.dbg_state), 32'(ST_WAIT_MEM));
  endtask

  task automatic respond(input logic [31:0] data);
    bus.mem_resp_valid = 1'b1;
    bus.mem_resp_data  = data;
    tick();
    bus.mem_resp_valid = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [5:0] op, input logic [31:0] rs1v,
                          input logic [31:0] imm, input logic [3:0] rd, input logic [31:0] resp,
                          input logic [31:0] exp_addr, input logic [2:0] exp_bytes,
                          input logic [31:0] exp_data);
    issue(op, imm, rd, rs1v, 32'd0);
    wait_req({tag, "_req"});
    check({tag, "_addr"}, bus.mem_req_addr, exp_addr);
    check({tag, "_bytes"}, 32'(bus.mem_req_bytes), 32'(exp_bytes));
    check({tag, "_we"}, 32'(bus.mem_req_we), 32'd0);
    respond(resp);
    check({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_rob"}, 32'(bus.out_rob), 32'(rd));
    check({tag, "_data"}, bus.out_data, exp_data);
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (sb_on && bus.mem_req_valid) begin
      if (exp_q.size() == 0) check("sb_req_extra", bus.mem_req_addr, 32'hFFFF_FFFF);
      else check("sb_req_addr", bus.mem_req_addr, exp_q.pop_front());
    end
    if (sb_on && bus.out_valid) begin
      if (exp_data_q.size() == 0) check("sb_out_extra", bus.out_data, 32'hFFFF_FFFF);
      else begin
        check("sb_out_data", bus.out_data, exp_data_q.pop_front());
        check("sb_out_rob", 32'(bus.out_rob), exp_rob_q.pop_front());
      end
    end
  end

  task automatic push_entry(input int k);
    exp_q.push_back(32'h1000 + 32'(k) * 4);
    exp_data_q.push_back(32'hA000 + 32'(k));
    exp_rob_q.push_back(32'(k % 16));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.rdy = 1'b1; bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_op = '0;
    bus.issue_imm = '0; bus.issue_rd_rob = '0; bus.issue_rs1_val = '0; bus.issue_rs2_val = '0;
    bus.issue_rs1_rob = '0; bus.issue_rs2_rob = '0; bus.issue_rs1_rdy = 1'b0;
    bus.issue_rs2_rdy = 1'b0; bus.mem_resp_valid = 1'b0; bus.mem_resp_data = '0;
    bus.store_commit_ok = 1'b0; bus.cdb0_valid = 1'b0; bus.cdb0_rob = '0; bus.cdb0_data = '0;
    bus.cdb1_valid = 1'b0; bus.cdb1_rob = '0; bus.cdb1_data = '0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("rst_avail", 32'(bus.lsq_avail), 32'd1);
    check("rst_req", 32'(bus.mem_req_valid), 32'd0);
    check("rst_out", 32'(bus.out_valid), 32'd0);
    check("rst_addr", bus.mem_req_addr, 32'd0);
    check("rst_odata", bus.out_data, 32'd0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Basic word load with request-pulse check
    issue(op_lw, 32'd4, 4'd5, 32'h100, 32'd0);
    wait_req("lw_req");
    check("lw_addr", bus.mem_req_addr, 32'h104);
    check("lw_bytes", 32'(bus.mem_req_bytes), 32'd4);
    check("lw_we", 32'(bus.mem_req_we), 32'd0);
    tick();
    check("lw_pulse", 32'(bus.mem_req_valid), 32'd0);
    respond(32'hDEADBEEF);
    check("lw_ov", 32'(bus.out_valid), 32'd1);
    check("lw_rob", 32'(bus.out_rob), 32'd5);
    check("lw_data", bus.out_data, 32'hDEADBEEF);
    tick();
    check("lw_ov_pulse", 32'(bus.out_valid), 32'd0);

    // Sign / zero extension
    run_load("lb",  op_lb,  32'h200, 32'd1, 4'd1, 32'h0000_0080, 32'h201, 3'd1, 32'hFFFF_FF80);
    run_load("lbu", op_lbu, 32'h200, 32'd2, 4'd2, 32'h0000_0080, 32'h202, 3'd1, 32'h0000_0080);
    run_load("lh",  op_lh,  32'h300, 32'd0, 4'd3, 32'h0000_8001, 32'h300, 3'd2, 32'hFFFF_8001);
    run_load("lhu", op_lhu, 32'h300, 32'd2, 4'd4, 32'h1234_8001, 32'h302, 3'd2, 32'h0000_8001);
    run_load("lwwrap", op_lw, 32'hFFFF_FFFC, 32'd8, 4'd6, 32'h5, 32'h4, 3'd4, 32'h5);

    // Store held until commit permission
    issue(op_sw, 32'd0, 4'd7, 32'h40, 32'h1234_5678);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("sw_hold", 32'(bus.mem_req_valid), 32'd0);
    end
    bus.store_commit_ok = 1'b1;
    tick();
    bus.store_commit_ok = 1'b0;
    check("sw_req", 32'(bus.mem_req_valid), 32'd1);
    check("sw_we", 32'(bus.mem_req_we), 32'd1);
    check("sw_wdata", bus.mem_req_wdata, 32'h1234_5678);
    check("sw_addr", bus.mem_req_addr, 32'h40);
    respond(32'hFFFF_FFFF);
    check("sw_ov", 32'(bus.out_valid), 32'd1);
    check("sw_data", bus.out_data, 32'd0);
    check("sw_rob", 32'(bus.out_rob), 32'd7);
    bus.store_commit_ok = 1'b1;
    issue(op_sb, 32'd1, 4'd8, 32'h44, 32'h1234_5678);
    wait_req("sb_req");
    check("sb_wdata", bus.mem_req_wdata, 32'h78);
    check("sb_bytes", 32'(bus.mem_req_bytes), 32'd1);
    check("sb_addr", bus.mem_req_addr, 32'h45);
    respond(32'd0);
    bus.store_commit_ok = 1'b0;

    // Issue-cycle bypass from cdb1
    drive_issue(op_lw, 32'd8, 4'd1, 32'hBAD, 1'b0, 4'd3, 32'd0);
    bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'd3; bus.cdb1_data = 32'h200;
    tick();
    bus.issue_valid = 1'b0; bus.cdb1_valid = 1'b0;
    wait_req("byp_req");
    check("byp_addr", bus.mem_req_addr, 32'h208);
    respond(32'h11);
    check("byp_data", bus.out_data, 32'h11);

    // Wakeup after issue; unrelated tag ignored; port 1 wins on double match
    drive_issue(op_lw, 32'h10, 4'd2, 32'hBAD, 1'b0, 4'd6, 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd5; bus.cdb0_data = 32'h900;
    tick();
    bus.cdb0_valid = 1'b0;
    repeat (2) tick();
    check("wk_wait", 32'(bus.dbg_state), 32'(ST_IDLE));
    bus.cdb0_valid = 1'b1; bus.cdb0_rob = 4'd6; bus.cdb0_data = 32'h300;
    bus.cdb1_valid = 1'b1; bus.cdb1_rob = 4'd6; bus.cdb1_data = 32'h400;
    tick();
    bus.cdb0_valid = 1'b0; bus.cdb1_valid = 1'b0;
    wait_req("wk_req");
    check("wk_addr", bus.mem_req_addr, 32'h410);
    respond(32'h22);

    // Fill to DEPTH, overflow issue ignored, then wrap with issue+pop in one cycle
    tick();
    sb_on = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_issue(op_lw, 32'd0, 4'(i), 32'h1000 + 32'(i) * 4, 1'b1, 4'd0, 32'd0);
      #1;
      if (i == 14) check("avail_14", 32'(bus.lsq_avail), 32'd1);
      if (i == 15) check("avail_15", 32'(bus.lsq_avail), 32'd0);
      push_entry(i);
      tick();
    end
    drive_issue(op_lw, 32'd0, 4'd15, 32'hF000, 1'b1, 4'd0, 32'd0);
    tick();
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      wait_busy("fill_busy");
      respond(32'hA000 + 32'(k));
    end
    for (int i = 16; i < 31; i++) begin
      drive_issue(op_lw, 32'd0, 4'(i % 16), 32'h1000 + 32'(i) * 4, 1'b1, 4'd0, 32'd0);
      push_entry(i);
      tick();
    end
    bus.issue_valid = 1'b0;
    wait_busy("wrap_busy0");
    drive_issue(op_lw, 32'd0, 4'd15, 32'h1000 + 32'd31 * 4, 1'b1, 4'd0, 32'd0);
    push_entry(31);
    respond(32'hA000 + 32'd16);
    bus.issue_valid = 1'b0;
    #1;
    check("wrap_avail_idle", 32'(bus.lsq_avail), 32'd1);
    bus.issue_valid = 1'b1;
    #1;
    check("wrap_avail_iss", 32'(bus.lsq_avail), 32'd0);
    bus.issue_valid = 1'b0;
    for (int k = 17; k < 32; k++) begin
      wait_busy("wrap_busy");
      respond(32'hA000 + 32'(k));
    end
    repeat (4) tick();
    check("sb_req_left", 32'(exp_q.size()), 32'd0);
    check("sb_out_left", 32'(exp_data_q.size()), 32'd0);
    check("wrap_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    sb_on = 1'b0;

    // Global enable low: issue not taken
    bus.rdy = 1'b0;
    issue(op_lw, 32'd0, 4'd1, 32'h700, 32'd0);
    bus.rdy = 1'b1;
    repeat (3) tick();
    check("rdy_hold", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Flush with issue in the same cycle: issue dropped
    drive_issue(op_lw, 32'd0, 4'd1, 32'h700, 1'b1, 4'd0, 32'd0);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0; bus.issue_valid = 1'b0;
    repeat (3) tick();
    check("flush_iss", 32'(bus.dbg_state), 32'(ST_IDLE));

    // Flush during WAIT_MEM swallows the late response
    issue(op_lw, 32'd0, 4'd3, 32'h600, 32'd0);
    wait_busy("fl_busy");
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("fl_drain", 32'(bus.dbg_state), 32'(ST_DRAIN));
    tick();
    respond(32'h77);
    check("fl_no_out", 32'(bus.out_valid), 32'd0);
    check("fl_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
    run_load("post_fl", op_lw, 32'h500, 32'd0, 4'd2, 32'h33, 32'h500, 3'd4, 32'h33);

    // Reset mid-transaction: response dropped, no DRAIN
    issue(op_lw, 32'd0, 4'd9, 32'h800, 32'd0);
    wait_busy("rst_busy");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    check("rst_mid_addr", bus.mem_req_addr, 32'd0);
    respond(32'h99);
    check("rst_mid_out", 32'(bus.out_valid), 32'd0);
    check("rst_mid_idle", 32'(bus.dbg_state), 32'(ST_IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
